// File: rtl/hiscore_ram_arbiter.sv
// Arbitrates the game work-RAM hiscore port: pauses the CPU, lets the bus settle,
// serves single-beat reads/writes, then hands the port back after an idle period.
module hiscore_ram_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 8,
    parameter int SETTLE    = 4,
    parameter int RD_LAT    = 1,
    parameter int IDLE_HOLD = 16
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          req_valid,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          req_ready,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          pause_req,
    input  logic          cpu_paused,
    input  logic          dl_active,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    output logic          ram_access,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    localparam int CMAX_SR = (SETTLE > RD_LAT) ? SETTLE : RD_LAT;
    localparam int CMAX    = (IDLE_HOLD > CMAX_SR) ? IDLE_HOLD : CMAX_SR;
    localparam int CW      = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_PAUSING, ST_SETTLE, ST_GRANT, ST_WRITE, ST_READ, ST_RELEASE
    } state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata, r_rdata;
    logic          r_rsp_valid;
    logic          w_in_access, w_hs, w_rd_done;

    // Access-phase outputs are gated by cpu_paused so the RAM mux lets go the
    // same cycle the pause is lost, not one cycle later.
    always_comb begin
        w_in_access = (r_state == ST_SETTLE) || (r_state == ST_GRANT) ||
                      (r_state == ST_WRITE)  || (r_state == ST_READ);
        req_ready   = (r_state == ST_GRANT) && cpu_paused && !dl_active;
        w_hs        = req_valid && req_ready;
        ram_access  = w_in_access && cpu_paused;
        pause_req   = (r_state != ST_IDLE);
        busy        = (r_state != ST_IDLE);
        ram_we      = (r_state == ST_WRITE);
    end

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_rd_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                if (req_valid && !dl_active) w_next = ST_PAUSING;
            end
            ST_PAUSING: begin
                if (dl_active) begin
                    w_next = ST_RELEASE;
                end else if (cpu_paused) begin
                    w_next     = ST_SETTLE;
                    w_cnt_next = CW'(SETTLE - 1);
                end
            end
            ST_SETTLE, ST_GRANT, ST_WRITE, ST_READ: begin
                // Download beats a lost pause; a write in its cycle still completes.
                if (dl_active) begin
                    w_next     = ST_RELEASE;
                    w_cnt_next = '0;
                end else if (!cpu_paused) begin
                    w_next     = ST_PAUSING;
                    w_cnt_next = '0;
                end else begin
                    case (r_state)
                        ST_SETTLE: begin
                            if (r_cnt == '0) w_next = ST_GRANT;
                            else             w_cnt_next = r_cnt - CW'(1);
                        end
                        ST_GRANT: begin
                            if (w_hs) begin
                                w_next     = req_write ? ST_WRITE : ST_READ;
                                w_cnt_next = CW'(RD_LAT - 1);
                            end else if (r_cnt == CW'(IDLE_HOLD - 1)) begin
                                w_next     = ST_RELEASE;
                                w_cnt_next = '0;
                            end else begin
                                w_cnt_next = r_cnt + CW'(1);
                            end
                        end
                        ST_WRITE: begin
                            w_next     = ST_GRANT;
                            w_cnt_next = '0;
                        end
                        default: begin
                            if (r_cnt == '0) begin
                                w_next     = ST_GRANT;
                                w_rd_done  = 1'b1;
                            end else begin
                                w_cnt_next = r_cnt - CW'(1);
                            end
                        end
                    endcase
                end
            end
            ST_RELEASE: begin
                w_next     = ST_IDLE;
                w_cnt_next = '0;
            end
            default: begin
                w_next     = ST_IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_rsp_valid <= w_rd_done;
            if (w_hs)              r_addr  <= req_addr;
            if (w_hs && req_write) r_wdata <= req_wdata;
            if (w_rd_done)         r_rdata <= ram_rdata;
        end
    end

    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Directed bench for hiscore_ram_arbiter: pause block modelled as a 3-cycle delay
// of pause_req, RAM modelled as a combinational-read array.
module tb_hiscore_ram_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        req_ready, rsp_valid, pause_req, cpu_paused, ram_we, ram_access, busy;
    logic [7:0]  rsp_rdata, ram_wdata, ram_rdata;
    logic [15:0] ram_addr;
    logic        dl_active = 1'b0;
    logic        force_low = 1'b0;
    logic [2:0]  dly = '0;
    logic [7:0]  mem [0:65535];
    int          we_cnt = 0, rsp_cnt = 0;
    int          n_cmp = 0, n_err = 0;

    hiscore_ram_arbiter dut (
        .clk_sys(clk_sys), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .pause_req(pause_req), .cpu_paused(cpu_paused), .dl_active(dl_active),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_access(ram_access), .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    assign cpu_paused = dly[2] & ~force_low;
    assign ram_rdata  = (ram_addr == 16'h6000) ? 8'h5A : mem[ram_addr];

    always @(posedge clk_sys) begin
        dly <= {dly[1:0], pause_req};
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            we_cnt        <= we_cnt + 1;
        end
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_sys);
    endtask

    task automatic wait_ready(input string tag, output int n);
        n = 0;
        while (!req_ready && n < 40) begin
            next();
            mid();
            n++;
        end
        check(tag, req_ready, 1'b1);
    endtask

    function automatic logic [63:0] all_outs();
        return {26'd0, req_ready, rsp_valid, pause_req, ram_access, ram_we, busy,
                ram_addr, ram_wdata, rsp_rdata};
    endfunction

    int n, first_pause, snap, bad;

    initial begin
        repeat (3) next();
        reset = 1'b0;
        mid();
        check("reset_outs", all_outs(), 64'd0);

        // Read 0x6000: pause at cycle 1, grant at cycle 9, data two cycles after handshake.
        next();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h6000;
        mid();
        check("c0_pause", pause_req, 1'b0);
        first_pause = -1;
        n = 0;
        while (!req_ready && n < 40) begin
            next();
            mid();
            n++;
            if (pause_req && first_pause < 0) first_pause = n;
        end
        check("first_pause_cycle", first_pause, 1);
        check("first_ready_cycle", n, 9);
        next();
        req_valid = 1'b0;
        mid();
        check("rd_addr", ram_addr, 16'h6000);
        check("rd_no_early_rsp", rsp_valid, 1'b0);
        next();
        mid();
        check("rd_rsp_valid", rsp_valid, 1'b1);
        check("rd_rdata", rsp_rdata, 8'h5A);
        check("rd_ready_again", req_ready, 1'b1);

        // Write 0x6010 <- 0xA5 then read it back, back to back.
        snap = we_cnt;
        next();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h6010; req_wdata = 8'hA5;
        mid();
        check("wr_ready", req_ready, 1'b1);
        next();
        req_write = 1'b0;
        mid();
        check("wr_we", ram_we, 1'b1);
        check("wr_addr", ram_addr, 16'h6010);
        check("wr_data", ram_wdata, 8'hA5);
        check("wr_not_ready", req_ready, 1'b0);
        next();
        mid();
        check("wr_we_single", ram_we, 1'b0);
        check("rb_ready", req_ready, 1'b1);
        next();
        req_valid = 1'b0;
        mid();
        check("rb_addr", ram_addr, 16'h6010);
        next();
        mid();
        check("rb_rsp_valid", rsp_valid, 1'b1);
        check("rb_rdata", rsp_rdata, 8'hA5);
        check("we_pulses", we_cnt - snap, 1);

        // Idle release: 16 request-free GRANT cycles, then RELEASE, then IDLE.
        n = 1;
        while (ram_access && n < 40) begin
            next();
            mid();
            n++;
        end
        check("release_cycle", n, 17);
        check("release_pause", pause_req, 1'b1);
        check("release_busy", busy, 1'b1);
        next();
        mid();
        check("idle_pause", pause_req, 1'b0);
        check("idle_busy", busy, 1'b0);

        // Download starts during a READ: response dropped, port released.
        repeat (5) next();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h6000;
        mid();
        wait_ready("dl_wait_ready", n);
        snap = rsp_cnt;
        next();
        req_valid = 1'b0; dl_active = 1'b1;
        mid();
        next();
        mid();
        check("dl_access", ram_access, 1'b0);
        check("dl_rsp", rsp_valid, 1'b0);
        check("dl_release_pause", pause_req, 1'b1);
        next();
        req_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            mid();
            if (busy) bad++;
            next();
        end
        check("dl_hold_idle", bad, 0);
        check("dl_no_rsp", rsp_cnt - snap, 0);
        dl_active = 1'b0;
        mid();
        next();
        mid();
        check("dl_clear_pausing", pause_req, 1'b1);
        req_valid = 1'b0;

        // Pause lost in GRANT: access drops at once, full SETTLE after re-acknowledge.
        wait_ready("pl_wait_ready", n);
        next();
        force_low = 1'b1;
        mid();
        check("pl_access_same", ram_access, 1'b0);
        check("pl_ready_same", req_ready, 1'b0);
        next();
        mid();
        check("pl_pausing_req", pause_req, 1'b1);
        check("pl_pausing_access", ram_access, 1'b0);
        next();
        force_low = 1'b0;
        mid();
        n = 0;
        while (!req_ready && n < 40) begin
            next();
            mid();
            n++;
        end
        check("pl_resettle", n, 5);

        // Reset during SETTLE.
        next();
        reset = 1'b1;
        next();
        reset = 1'b0;
        mid();
        check("rst_grant_outs", all_outs(), 64'd0);
        repeat (5) next();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h6000;
        mid();
        n = 0;
        while (!(ram_access && !req_ready) && n < 40) begin
            next();
            mid();
            n++;
        end
        check("rst_found_settle", ram_access && !req_ready, 1'b1);
        reset = 1'b1; req_valid = 1'b0;
        next();
        reset = 1'b0;
        mid();
        check("rst_settle_outs", all_outs(), 64'd0);

        // Reset during WRITE.
        repeat (5) next();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h6020; req_wdata = 8'h3C;
        mid();
        wait_ready("rw_wait_ready", n);
        next();
        req_valid = 1'b0;
        mid();
        check("rw_we", ram_we, 1'b1);
        reset = 1'b1;
        next();
        reset = 1'b0;
        mid();
        check("rst_write_outs", all_outs(), 64'd0);
        snap = we_cnt;
        repeat (5) next();
        mid();
        check("rst_no_we", we_cnt - snap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
